// File: rtl/p2s_pkg.sv
// Shared types for the lane serialiser: FSM state and per-word output order.
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } p2s_order_t;

endpackage

// File: rtl/p2s_lanes.sv
// Parallel-to-serial converter: N-bit word in, N/W beats of W bits out,
// order chosen per word, last beat overlaps acceptance of the next word.
//
// state | meaning
// IDLE  | no word held, ready for a new word
// SHIFT | emitting beats of the held word; ready again on its last beat
module p2s_lanes
  import p2s_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] par_data,
  input  logic         par_msb_first,
  input  logic         par_valid,
  output logic         par_ready,
  output logic [W-1:0] ser_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last
);

  localparam int BEATS = N / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
    $error("p2s_lanes: N must be >= 1 and a multiple of W, with 1 <= W <= N");
  end

  p2s_state_t state, state_nxt;
  p2s_order_t order, order_nxt;
  logic [N-1:0]  sreg, sreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          beat_acc, par_acc;

  assign ser_valid = (state == SHIFT);
  assign ser_last  = ser_valid && (cnt == CW'(BEATS - 1));
  assign ser_data  = (order == MSB_FIRST) ? sreg[N-1 -: W] : sreg[W-1:0];

  // Ready looks through to ser_ready so the next word loads on the last beat.
  assign beat_acc  = ser_valid && ser_ready;
  assign par_ready = !rst && ((state == IDLE) || (beat_acc && ser_last));
  assign par_acc   = par_valid && par_ready;

  always_comb begin
    state_nxt = state;
    order_nxt = order;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    if (par_acc) begin
      state_nxt = SHIFT;
      order_nxt = p2s_order_t'(par_msb_first);
      sreg_nxt  = par_data;
      cnt_nxt   = '0;
    end else if (beat_acc) begin
      if (ser_last) begin
        state_nxt = IDLE;
        sreg_nxt  = '0;
        cnt_nxt   = '0;
      end else begin
        sreg_nxt = (order == MSB_FIRST) ? (sreg << W) : (sreg >> W);
        cnt_nxt  = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      order <= LSB_FIRST;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      order <= order_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_p2s_lanes.sv
// Scoreboard bench for p2s_lanes: an 8-bit/2-lane instance and a 4-bit/1-lane instance.
module tb_p2s_lanes;

  typedef struct {
    logic [1:0] d;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_pd;
  logic       a_msb, a_pv, a_pr, a_sv, a_sr, a_sl;
  logic [1:0] a_sd;

  logic [3:0] b_pd;
  logic       b_msb, b_pv, b_pr, b_sv, b_sr, b_sl;
  logic [0:0] b_sd;

  p2s_lanes #(.N(8), .W(2)) u_a (
    .clk(clk), .rst(rst),
    .par_data(a_pd), .par_msb_first(a_msb), .par_valid(a_pv), .par_ready(a_pr),
    .ser_data(a_sd), .ser_valid(a_sv), .ser_ready(a_sr), .ser_last(a_sl)
  );

  p2s_lanes #(.N(4), .W(1)) u_b (
    .clk(clk), .rst(rst),
    .par_data(b_pd), .par_msb_first(b_msb), .par_valid(b_pv), .par_ready(b_pr),
    .ser_data(b_sd), .ser_valid(b_sv), .ser_ready(b_sr), .ser_last(b_sl)
  );

  int    total = 0;
  int    bad   = 0;
  int    gaps  = 0;
  bit    gap_chk = 1'b0;
  beat_t qa[$];
  beat_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst && gap_chk && !a_sv) gaps++;
    if (!rst && a_sv && a_sr) begin
      if (qa.size() == 0) chk("a_extra_beat", 32'(qa.size()), 1);
      else begin
        e = qa.pop_front();
        chk("a_data", 32'(a_sd), 32'(e.d));
        chk("a_last", 32'(a_sl), 32'(e.last));
        chk("a_par_ready", 32'(a_pr), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && b_sv && b_sr) begin
      if (qb.size() == 0) chk("b_extra_beat", 32'(qb.size()), 1);
      else begin
        e = qb.pop_front();
        chk("b_data", 32'({1'b0, b_sd}), 32'(e.d));
        chk("b_last", 32'(b_sl), 32'(e.last));
      end
    end
  end

  task automatic put_a(input logic [7:0] d, input logic m,
                       input logic [1:0] e0, input logic [1:0] e1,
                       input logic [1:0] e2, input logic [1:0] e3);
    int n = 0;
    qa.push_back('{e0, 1'b0});
    qa.push_back('{e1, 1'b0});
    qa.push_back('{e2, 1'b0});
    qa.push_back('{e3, 1'b1});
    a_pd = d; a_msb = m; a_pv = 1'b1;
    @(negedge clk);
    while (!a_pr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept", 32'(a_pr), 1);
    @(posedge clk);
    #1 a_pv = 1'b0;
  endtask

  task automatic put_b(input logic [3:0] d, input logic m,
                       input logic e0, input logic e1, input logic e2, input logic e3);
    int n = 0;
    qb.push_back('{{1'b0, e0}, 1'b0});
    qb.push_back('{{1'b0, e1}, 1'b0});
    qb.push_back('{{1'b0, e2}, 1'b0});
    qb.push_back('{{1'b0, e3}, 1'b1});
    b_pd = d; b_msb = m; b_pv = 1'b1;
    @(negedge clk);
    while (!b_pr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept", 32'(b_pr), 1);
    @(posedge clk);
    #1 b_pv = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while ((qa.size() != 0 || a_sv) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("a_drain", 32'(qa.size()), 0);
  endtask

  task automatic drain_b();
    int n = 0;
    while ((qb.size() != 0 || b_sv) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_drain", 32'(qb.size()), 0);
  endtask

  initial begin
    rst = 1'b1;
    a_pd = '0; a_msb = 1'b0; a_pv = 1'b0; a_sr = 1'b1;
    b_pd = '0; b_msb = 1'b0; b_pv = 1'b0; b_sr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(a_sv), 0);
    chk("rst_last", 32'(a_sl), 0);
    chk("rst_data", 32'(a_sd), 0);
    chk("rst_par_ready", 32'(a_pr), 0);
    chk("rst_b_valid", 32'(b_sv), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rel_par_ready", 32'(a_pr), 1);

    put_a(8'hB4, 1'b1, 2'b10, 2'b11, 2'b01, 2'b00);
    drain_a();

    put_a(8'hB4, 1'b0, 2'b00, 2'b01, 2'b11, 2'b10);
    drain_a();

    gaps = 0;
    put_a(8'hA5, 1'b1, 2'b10, 2'b10, 2'b01, 2'b01);
    gap_chk = 1'b1;
    put_a(8'h3C, 1'b1, 2'b00, 2'b11, 2'b11, 2'b00);
    drain_a();
    gap_chk = 1'b0;
    chk("b2b_gaps", 32'(gaps), 0);

    put_a(8'hB4, 1'b1, 2'b10, 2'b11, 2'b01, 2'b00);
    @(posedge clk);
    #1;
    a_sr = 1'b0; a_pd = 8'hFF; a_msb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", 32'(a_sd), 32'(2'b11));
      chk("stall_valid", 32'(a_sv), 1);
      chk("stall_last", 32'(a_sl), 0);
      a_pd = ~a_pd;
      @(posedge clk);
    end
    #1 a_sr = 1'b1;
    drain_a();

    put_a(8'hB4, 1'b1, 2'b10, 2'b11, 2'b01, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_beat2", 32'(a_sd), 32'(2'b01));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(a_sv), 0);
    chk("mid_rst_last", 32'(a_sl), 0);
    chk("mid_rst_par_ready", 32'(a_pr), 0);
    qa.delete();
    rst = 1'b0;
    #1 chk("mid_rel_par_ready", 32'(a_pr), 1);
    put_a(8'h0F, 1'b1, 2'b00, 2'b00, 2'b11, 2'b11);
    drain_a();

    put_b(4'b1010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drain_b();
    put_b(4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 b_sr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("b_stall_data", 32'(b_sd), 1);
      chk("b_stall_valid", 32'(b_sv), 1);
      chk("b_stall_last", 32'(b_sl), 0);
      @(posedge clk);
    end
    #1 b_sr = 1'b1;
    drain_b();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p2s_lanes.md
# p2s_lanes

Parametrised parallel-to-serial converter, the next generation of the safe-lock `p2s` serialiser. It accepts an N-bit word over a valid/ready handshake and emits it as N/W beats of W bits on a valid/ready serial stream. The output order (MSB-first or LSB-first) is selectable per word, and `ser_last` marks the final beat. The last beat overlaps acceptance of the next word, so back-to-back words stream without a bubble. It sits between the keypad/code logic and the serial link.

## Interface
Parameters:
- N, default 8: parallel word width; must be ≥ 1 and divisible by W (elaboration-time assertion).
- W, default 1: serial lane width in bits; 1 ≤ W ≤ N.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- par_data, input, N: word to serialise.
- par_msb_first, input, 1: order for this word; 1 = MSB lane first, 0 = LSB lane first.
- par_valid, input, 1: word valid.
- par_ready, output, 1: word accepted on the cycle where par_valid && par_ready.
- ser_data, output, W: current lane.
- ser_valid, output, 1: lane valid.
- ser_ready, input, 1: lane consumed on the cycle where ser_valid && ser_ready.
- ser_last, output, 1: current lane is the final beat of the word.

## Operation
- BEATS = N/W. The beat counter is $clog2(BEATS) bits wide, with a minimum of 1.
- Registers:
  - Shift register sreg[N-1:0].
  - Captured order bit.
  - Beat counter.
  - State in {IDLE, SHIFT}.
- Lane selection:
  - ser_data = sreg[N-1 -: W] when MSB-first, otherwise sreg[W-1:0].
  - Each accepted beat shifts sreg by W toward the emitting end, zero-filling.
- ser_valid = (state == SHIFT).
- ser_last = ser_valid && (cnt == BEATS-1).
- par_ready = !rst && (state == IDLE || (ser_valid && ser_ready && ser_last)). This is combinational from ser_ready; a combinational path ser_ready → par_ready is permitted.
- IDLE → SHIFT on par accept: load sreg = par_data, capture par_msb_first, cnt = 0.
- SHIFT, beat accepted and not last: shift, cnt++.
- SHIFT, beat accepted and last:
  - If a par accept occurs in the same cycle, reload with the new word (cnt = 0, stay in SHIFT).
  - Otherwise go to IDLE.
- SHIFT with ser_ready = 0: all state holds. ser_data, ser_valid and ser_last stay stable, and ser_valid never drops mid-word (AXI-style rule).
- par_data and par_msb_first are sampled only at acceptance. Changes at any other time have no effect.
- BEATS = 1 (W = N): every beat is last, giving one word per cycle under continuous ready.

## Timing
- Reset values (cycle after rst is sampled high):
  - state = IDLE, sreg = 0, cnt = 0.
  - ser_valid = 0, ser_last = 0, ser_data = 0.
  - par_ready is held 0 while rst is high and goes to 1 the first cycle after rst falls.
- Latency: a word accepted at edge k puts beat 0 on ser_data after edge k (visible in cycle k+1).
- Throughput with ser_ready held high: one beat per cycle and BEATS cycles per word, with no idle cycle between back-to-back words.
- Reset mid-word: the partial word is discarded with no further beats, and ser_last is never emitted for it.
- rst has priority over any simultaneous handshake.

## Structure
- Package p2s_pkg holds:
  - typedef enum logic {IDLE, SHIFT} p2s_state_t.
  - typedef enum logic {LSB_FIRST = 0, MSB_FIRST = 1} p2s_order_t.
- Single module, no sub-module. Shift register, counter and FSM are small enough to be inline.
- Parameter legality is checked with an initial/elaboration assertion.

## Test plan
All scenarios use N=8, W=2 unless stated.
- MSB-first: rst, then par_data = 8'hB4, msb_first = 1, ser_ready = 1 → beats 2'b10, 2'b11, 2'b01, 2'b00 on consecutive cycles; ser_last only on the 4th beat; par_ready low for beats 1–3 and high on the 4th.
- LSB-first: same word with msb_first = 0 → beats 00, 01, 11, 10.
- Back-to-back: par_valid held high with 8'hA5, then 8'h3C (MSB-first) → 8 contiguous valid beats 10, 10, 01, 01, 00, 11, 11, 00; no cycle with ser_valid = 0 between words.
- Backpressure: ser_ready = 0 for 3 cycles after beat 1 of 8'hB4 → ser_data holds 2'b11, ser_valid stays high, sequence then resumes unchanged; par_data toggled during the stall has no effect.
- Reset mid-word: rst pulsed during beat 2 → next cycle ser_valid = 0 and ser_last = 0; after release, word 8'h0F streams cleanly from beat 0.
- Legacy configuration N=4, W=1, MSB-first: 4'b1010 → 1, 0, 1, 0; then 4'b1111 with a 2-cycle ser_ready drop → 1, 1, 1, 1 with the held bit stable during the stall.
